cb_stream_ctrl: RTL

Frame-level sequencer for the contrast/brightness pixel path. Accepts a start command with a per-frame gain/offset and word count. Streams that many packed 4-pixel words from an upstream valid/ready source through a registered, saturating `y = alpha*p + beta` stage to a downstream valid/ready sink. Signals completion with a one-cycle `done` pulse. Sits between the frame buffer reader and the output writer in the image pipeline.

---
 rtl/cb_pkg.sv | 16 +
 rtl/cb_pixel_sat.sv | 30 +++
 rtl/cb_stream_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cb_pkg.sv
// Shared types and constants for the contrast/brightness stream controller.
package cb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cb_state_t;

    localparam int PIX_W      = 8;
    localparam int WORD_W     = 32;
    localparam int ALPHA_FRAC = 4;
    localparam logic [7:0] ALPHA_ONE = 8'h10;

endpackage

// File: rtl/cb_pixel_sat.sv
// Single-pixel y = alpha*p + beta with Q4.4 gain and clamp to 0..255.
module cb_pixel_sat
    import cb_pkg::*;
(
    input  logic [7:0] alpha,
    input  logic [8:0] beta,
    input  logic [7:0] pix,
    output logic [7:0] result
);

    logic [2*PIX_W-1:0]      prod;
    logic [11:0]             scaled;
    logic signed [13:0]      sum;

    // Multiply, drop the fractional gain bits, add the offset and clamp.
    // The sum carries one bit beyond the nominal 13 so that the largest
    // gain/offset combinations still clamp high instead of wrapping.
    always_comb begin
        prod   = {8'b0, alpha} * {8'b0, pix};
        scaled = prod[2*PIX_W-1:ALPHA_FRAC];
        sum    = signed'({2'b00, scaled}) + signed'({{5{beta[8]}}, beta});
        result = sum[7:0];
        if (sum[13]) begin
            result = 8'h00;
        end else if (sum[12:8] != 5'd0) begin
            result = 8'hFF;
        end
    end

endmodule

// File: rtl/cb_stream_ctrl.sv
// Frame sequencer: streams frame_words packed pixel words through the
// saturating gain/offset stage into a one-entry output register.
module cb_stream_ctrl
    import cb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       alpha,
    input  logic [8:0]       beta,
    input  logic [CNT_W-1:0] frame_words,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    cb_state_t          state_reg, state_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   words_reg;
    logic [7:0]         alpha_reg;
    logic [8:0]         beta_reg;
    logic               out_valid_reg;
    logic [WORD_W-1:0]  out_data_reg;
    logic [WORD_W-1:0]  result;
    logic               hs_in;
    logic               hs_out;
    logic               last_in;
    logic               start_ok;
    logic               abort_act;

    // Output register can accept a word when empty or being drained this cycle.
    assign in_ready  = (state_reg == ST_RUN) && (!out_valid_reg || out_ready);
    assign hs_in     = in_valid && in_ready;
    assign hs_out    = out_valid_reg && out_ready;
    // words_reg is at least 1 in RUN, so count never passes it and never wraps.
    assign last_in   = hs_in && (count_reg == (words_reg - CNT_ONE));
    assign start_ok  = (state_reg == ST_IDLE) && start && (frame_words != '0);
    assign abort_act = abort && (state_reg != ST_IDLE);

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);

    // Four independent lanes, [31:24] is the first pixel.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            cb_pixel_sat u_pix (
                .alpha  (alpha_reg),
                .beta   (beta_reg),
                .pix    (in_data[gi*PIX_W +: PIX_W]),
                .result (result[gi*PIX_W +: PIX_W])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (frame_words != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_in) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_reg || out_ready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort_act) begin
            state_next = ST_IDLE;
        end
    end

    // Frame configuration and input word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            words_reg <= '0;
            alpha_reg <= '0;
            beta_reg  <= '0;
        end else if (abort_act) begin
            count_reg <= '0;
        end else if (start_ok) begin
            count_reg <= '0;
            words_reg <= frame_words;
            alpha_reg <= alpha;
            beta_reg  <= beta;
        end else if (hs_in) begin
            count_reg <= count_reg + CNT_ONE;
        end
    end

    // One-entry output register; a load and an unload in the same cycle
    // simply replace the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (abort_act) begin
            out_valid_reg <= 1'b0;
        end else if (hs_in) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= result;
        end else if (hs_out) begin
            out_valid_reg <= 1'b0;
        end
    end

endmodule
